// File: rtl/instr_encoder_loader_if.sv
// Request channel between the boot/test host and the instruction loader.
// The host drives one RV32I encode request per valid/ready handshake.
interface instr_encoder_loader_if;
    logic        enc_valid;
    logic        enc_ready;
    logic [2:0]  enc_kind;
    logic [4:0]  enc_rd;
    logic [4:0]  enc_rs1;
    logic [4:0]  enc_rs2;
    logic [2:0]  enc_funct3;
    logic        enc_funct7b5;
    logic [31:0] enc_imm;
    logic        enc_last;

    modport master (
        output enc_valid, enc_kind, enc_rd, enc_rs1, enc_rs2,
        output enc_funct3, enc_funct7b5, enc_imm, enc_last,
        input  enc_ready
    );

    modport slave (
        input  enc_valid, enc_kind, enc_rd, enc_rs1, enc_rs2,
        input  enc_funct3, enc_funct7b5, enc_imm, enc_last,
        output enc_ready
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and program loader; holds the core in reset while loading.
// Optional running checksum of written words is built when LOADER_CHECKSUM_EN is defined.
module instr_encoder_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    instr_encoder_loader_if.slave  enc,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wd,
    output logic                   core_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ADDR_W:0]        count,
    output logic [31:0]            checksum
);
    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [6:0]  OP_R     = 7'b0110011;
    localparam logic [6:0]  OP_I     = 7'b0010011;
    localparam logic [6:0]  OP_B     = 7'b1100011;
    localparam logic [6:0]  OP_J     = 7'b1101111;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic        enter;
    logic        accept;
    logic        overflow;
    logic [31:0] wptr;
    logic [31:0] word;
    logic        bad;

    assign accept   = enc.enc_valid & enc.enc_ready;
    assign overflow = accept & ~enc.enc_last & (count == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        enc.enc_ready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        core_rst      = 1'b1;
        enter         = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    enter    = 1'b1;
                end
            end
            LOAD: begin
                busy          = 1'b1;
                enc.enc_ready = (count < DEPTH);
                if (accept && (enc.enc_last || count == LAST_IDX))
                    state_nx = FLUSH;
            end
            FLUSH: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                core_rst = 1'b0;
                if (start) begin
                    state_nx = LOAD;
                    enter    = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    logic [31:0] imm;
    logic [6:0]  f7;
    logic        fit12;
    logic        fit13;
    logic        fit21;
    logic        shamt_ok;
    logic        is_shift;

    assign imm      = enc.enc_imm;
    assign f7       = {1'b0, enc.enc_funct7b5, 5'b00000};
    assign fit12    = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fit13    = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign fit21    = (imm[31:20] == '0) || (imm[31:20] == '1);
    assign shamt_ok = (imm[31:5] == '0);
    assign is_shift = (enc.enc_funct3 == 3'b001) ||
                      (enc.enc_funct3 == 3'b101);

    always_comb begin
        word = NOP;
        bad  = 1'b0;
        unique case (1'b1)
            (enc.enc_kind == 3'd0): begin
                word = {imm[11:0], enc.enc_rs1, enc.enc_funct3,
                        enc.enc_rd, OP_LOAD};
                bad  = ~fit12;
            end
            (enc.enc_kind == 3'd1): begin
                word = {imm[11:5], enc.enc_rs2, enc.enc_rs1,
                        enc.enc_funct3, imm[4:0], OP_STORE};
                bad  = ~fit12;
            end
            (enc.enc_kind == 3'd2): begin
                word = {f7, enc.enc_rs2, enc.enc_rs1, enc.enc_funct3,
                        enc.enc_rd, OP_R};
            end
            (enc.enc_kind == 3'd3): begin
                if (is_shift) begin
                    word = {f7, imm[4:0], enc.enc_rs1, enc.enc_funct3,
                            enc.enc_rd, OP_I};
                    bad  = ~shamt_ok;
                end else begin
                    word = {imm[11:0], enc.enc_rs1, enc.enc_funct3,
                            enc.enc_rd, OP_I};
                    bad  = ~fit12;
                end
            end
            (enc.enc_kind == 3'd4): begin
                word = {imm[12], imm[10:5], enc.enc_rs2, enc.enc_rs1,
                        enc.enc_funct3, imm[4:1], imm[11], OP_B};
                bad  = ~fit13 | imm[0];
            end
            (enc.enc_kind == 3'd5): begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12],
                        enc.enc_rd, OP_J};
                bad  = ~fit21 | imm[0];
            end
            default: bad = 1'b1;
        endcase
        // Rejected requests still occupy a slot so later addresses stay put.
        if (bad) word = NOP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we   <= 1'b0;
            mem_addr <= BASE_ADDR;
            mem_wd   <= 32'h0;
            wptr     <= BASE_ADDR;
            err      <= 1'b0;
            count    <= '0;
        end else begin
            mem_we <= accept;
            if (enter) begin
                mem_addr <= BASE_ADDR;
                wptr     <= BASE_ADDR;
                err      <= 1'b0;
                count    <= '0;
            end else if (accept) begin
                mem_addr <= wptr;
                mem_wd   <= word;
                wptr     <= wptr + 32'd4;
                count    <= count + CNT_ONE;
                if (bad || overflow) err <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || enter) checksum <= 32'h0;
        else if (accept)  checksum <= checksum + word;
    end
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: default-depth instance plus a
// four-word instance for the capacity-overflow path.
module tb_instr_encoder_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic s_start = 1'b0;

    always #5 clk = ~clk;

    instr_encoder_loader_if bus ();
    instr_encoder_loader_if sbus ();

    logic        mem_we, core_rst, busy, done, err;
    logic [31:0] mem_addr, mem_wd, checksum;
    logic [10:0] count;

    logic        s_mem_we, s_core_rst, s_busy, s_done, s_err;
    logic [31:0] s_mem_addr, s_mem_wd, s_checksum;
    logic [2:0]  s_count;

    int tests = 0;
    int fails = 0;

`ifdef LOADER_CHECKSUM_EN
    localparam logic [31:0] CS1 = 32'h0080_2283;
    localparam logic [31:0] CS2 = 32'h00D0_48A6;
`else
    localparam logic [31:0] CS1 = 32'h0;
    localparam logic [31:0] CS2 = 32'h0;
`endif

    instr_encoder_loader u_dut (
        .clk(clk), .rst(rst), .start(start), .enc(bus),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .core_rst(core_rst), .busy(busy), .done(done), .err(err),
        .count(count), .checksum(checksum)
    );

    instr_encoder_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .enc(sbus),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wd(s_mem_wd),
        .core_rst(s_core_rst), .busy(s_busy), .done(s_done), .err(s_err),
        .count(s_count), .checksum(s_checksum)
    );

    task automatic req(input logic [2:0] k, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic f7b5,
                       input logic [31:0] imm, input logic last);
        bus.enc_valid    = 1'b1;
        bus.enc_kind     = k;
        bus.enc_rd       = rd;
        bus.enc_rs1      = rs1;
        bus.enc_rs2      = rs2;
        bus.enc_funct3   = f3;
        bus.enc_funct7b5 = f7b5;
        bus.enc_imm      = imm;
        bus.enc_last     = last;
    endtask

    task automatic idle_req();
        bus.enc_valid = 1'b0;
        bus.enc_last  = 1'b0;
    endtask

    task automatic start_big();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({mem_we, mem_addr, mem_wd} !== {1'b0, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL reset_mem: got we=%0b addr=%h wd=%h want 0/0/0", mem_we, mem_addr, mem_wd);
        end
        tests++;
        if ({core_rst, busy, done, err, bus.enc_ready} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_ctrl: got rst/busy/done/err/rdy=%b want 10000", {core_rst, busy, done, err, bus.enc_ready});
        end
        tests++;
        if (count !== 11'd0 || checksum !== 32'h0) begin
            fails++;
            $display("FAIL reset_count: got count=%0d cs=%h want 0/0", count, checksum);
        end
        tests++;
        if ({s_core_rst, s_busy, s_done, s_err, s_count} !== {4'b1000, 3'd0}) begin
            fails++;
            $display("FAIL reset_small: got %b want 1000000", {s_core_rst, s_busy, s_done, s_err, s_count});
        end
        rst = 1'b0;
    endtask

    task automatic test_r_type();
        start_big();
        tests++;
        if ({busy, core_rst, bus.enc_ready} !== 3'b111) begin
            fails++;
            $display("FAIL load_entry: got busy/core_rst/rdy=%b want 111", {busy, core_rst, bus.enc_ready});
        end
        req(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        idle_req();
        tests++;
        if ({mem_we, mem_addr, mem_wd} !== {1'b1, 32'h0, 32'h002081B3}) begin
            fails++;
            $display("FAIL add_write: got we=%0b addr=%h wd=%h want 1/0/002081b3", mem_we, mem_addr, mem_wd);
        end
        @(negedge clk);
        tests++;
        if ({done, core_rst, busy, mem_we, err} !== 5'b10000 || count !== 11'd1) begin
            fails++;
            $display("FAIL add_done: got done/crst/busy/we/err=%b count=%0d want 10000 count=1", {done, core_rst, busy, mem_we, err}, count);
        end
    endtask

    task automatic test_back_to_back();
        start_big();
        req(3'd0, 5'd5, 5'd0, 5'd0, 3'b010, 1'b0, 32'd8, 1'b0);
        @(negedge clk);
        req(3'd1, 5'd0, 5'd0, 5'd5, 3'b010, 1'b0, 32'd12, 1'b1);
        tests++;
        if ({mem_we, mem_addr, mem_wd} !== {1'b1, 32'h0, 32'h00802283} || checksum !== CS1) begin
            fails++;
            $display("FAIL lw_write: got we=%0b addr=%h wd=%h cs=%h want 1/0/00802283 cs=%h", mem_we, mem_addr, mem_wd, checksum, CS1);
        end
        @(negedge clk);
        idle_req();
        tests++;
        if ({mem_we, mem_addr, mem_wd} !== {1'b1, 32'h4, 32'h00502623} || checksum !== CS2) begin
            fails++;
            $display("FAIL sw_write: got we=%0b addr=%h wd=%h cs=%h want 1/4/00502623 cs=%h", mem_we, mem_addr, mem_wd, checksum, CS2);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || count !== 11'd2 || checksum !== CS2 || mem_wd !== 32'h00502623) begin
            fails++;
            $display("FAIL b2b_hold: got done=%0b count=%0d cs=%h wd=%h want 1/2/%h/00502623", done, count, checksum, mem_wd, CS2);
        end
    endtask

    task automatic test_branch_jal();
        start_big();
        req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFF8, 1'b0);
        @(negedge clk);
        req(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd16, 1'b1);
        tests++;
        if ({mem_we, mem_addr, mem_wd} !== {1'b1, 32'h0, 32'hFE208CE3}) begin
            fails++;
            $display("FAIL beq_write: got we=%0b addr=%h wd=%h want 1/0/fe208ce3", mem_we, mem_addr, mem_wd);
        end
        @(negedge clk);
        idle_req();
        tests++;
        if ({mem_we, mem_addr, mem_wd} !== {1'b1, 32'h4, 32'h010000EF}) begin
            fails++;
            $display("FAIL jal_write: got we=%0b addr=%h wd=%h want 1/4/010000ef", mem_we, mem_addr, mem_wd);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || err !== 1'b0 || count !== 11'd2) begin
            fails++;
            $display("FAIL bj_done: got done=%0b err=%0b count=%0d want 1/0/2", done, err, count);
        end
    endtask

    task automatic test_shift();
        start_big();
        req(3'd3, 5'd1, 5'd2, 5'd0, 3'b101, 1'b1, 32'd3, 1'b0);
        @(negedge clk);
        req(3'd3, 5'd1, 5'd2, 5'd0, 3'b001, 1'b0, 32'd32, 1'b1);
        tests++;
        if ({mem_we, mem_wd, err} !== {1'b1, 32'h40315093, 1'b0}) begin
            fails++;
            $display("FAIL srai_write: got we=%0b wd=%h err=%0b want 1/40315093/0", mem_we, mem_wd, err);
        end
        @(negedge clk);
        idle_req();
        tests++;
        if ({mem_we, mem_addr, mem_wd, err} !== {1'b1, 32'h4, 32'h13, 1'b1}) begin
            fails++;
            $display("FAIL shamt_range: got we=%0b addr=%h wd=%h err=%0b want 1/4/13/1", mem_we, mem_addr, mem_wd, err);
        end
        @(negedge clk);
    endtask

    task automatic test_errors();
        start_big();
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear_start: got err=%0b want 0", err);
        end
        req(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        req(3'd3, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 32'd2048, 1'b0);
        tests++;
        if ({mem_we, mem_addr, mem_wd, err} !== {1'b1, 32'h0, 32'h13, 1'b1}) begin
            fails++;
            $display("FAIL illegal_kind: got we=%0b addr=%h wd=%h err=%0b want 1/0/13/1", mem_we, mem_addr, mem_wd, err);
        end
        @(negedge clk);
        req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3, 1'b1);
        tests++;
        if ({mem_we, mem_addr, mem_wd} !== {1'b1, 32'h4, 32'h13}) begin
            fails++;
            $display("FAIL imm_range: got we=%0b addr=%h wd=%h want 1/4/13", mem_we, mem_addr, mem_wd);
        end
        @(negedge clk);
        idle_req();
        tests++;
        if ({mem_we, mem_addr, mem_wd} !== {1'b1, 32'h8, 32'h13}) begin
            fails++;
            $display("FAIL odd_branch: got we=%0b addr=%h wd=%h want 1/8/13", mem_we, mem_addr, mem_wd);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || err !== 1'b1 || count !== 11'd3) begin
            fails++;
            $display("FAIL err_done: got done=%0b err=%0b count=%0d want 1/1/3", done, err, count);
        end
        start_big();
        tests++;
        if (err !== 1'b0 || busy !== 1'b1 || count !== 11'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL err_restart: got err=%0b busy=%0b count=%0d done=%0b want 0/1/0/0", err, busy, count, done);
        end
        req(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        idle_req();
        tests++;
        if ({mem_we, mem_wd, err} !== {1'b1, 32'h13, 1'b0}) begin
            fails++;
            $display("FAIL legal_nop: got we=%0b wd=%h err=%0b want 1/13/0", mem_we, mem_wd, err);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        sbus.enc_valid    = 1'b1;
        sbus.enc_kind     = 3'd2;
        sbus.enc_rd       = 5'd3;
        sbus.enc_rs1      = 5'd1;
        sbus.enc_rs2      = 5'd2;
        sbus.enc_funct3   = 3'd0;
        sbus.enc_funct7b5 = 1'b0;
        sbus.enc_imm      = 32'd0;
        sbus.enc_last     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if ({s_mem_we, s_mem_addr, s_count} !== {1'b1, 32'(4 * i), 3'(i + 1)}) begin
                fails++;
                $display("FAIL ovf_write%0d: got we=%0b addr=%h count=%0d want 1/%h/%0d", i, s_mem_we, s_mem_addr, s_count, 32'(4 * i), i + 1);
            end
        end
        tests++;
        if (sbus.enc_ready !== 1'b0 || s_err !== 1'b1) begin
            fails++;
            $display("FAIL ovf_ready: got rdy=%0b err=%0b want 0/1", sbus.enc_ready, s_err);
        end
        @(negedge clk);
        sbus.enc_valid = 1'b0;
        tests++;
        if ({s_done, s_err, s_mem_we, s_core_rst} !== 4'b1100 || s_count !== 3'd4) begin
            fails++;
            $display("FAIL ovf_done: got done/err/we/crst=%b count=%0d want 1100 count=4", {s_done, s_err, s_mem_we, s_core_rst}, s_count);
        end
    endtask

    task automatic test_reset_mid();
        start_big();
        req(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        req(3'd2, 5'd4, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        idle_req();
        tests++;
        if ({mem_we, mem_addr, count} !== {1'b1, 32'h4, 11'd2}) begin
            fails++;
            $display("FAIL mid_second: got we=%0b addr=%h count=%0d want 1/4/2", mem_we, mem_addr, count);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({core_rst, busy, mem_we, done} !== 4'b1000 || count !== 11'd0 || mem_addr !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset: got crst/busy/we/done=%b count=%0d addr=%h want 1000/0/0", {core_rst, busy, mem_we, done}, count, mem_addr);
        end
        start_big();
        req(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        idle_req();
        tests++;
        if ({mem_we, mem_addr, mem_wd, count} !== {1'b1, 32'h0, 32'h002081B3, 11'd1}) begin
            fails++;
            $display("FAIL mid_rewrite: got we=%0b addr=%h wd=%h count=%0d want 1/0/002081b3/1", mem_we, mem_addr, mem_wd, count);
        end
        @(negedge clk);
    endtask

    initial begin
        idle_req();
        bus.enc_kind = 3'd0;
        bus.enc_rd = 5'd0;
        bus.enc_rs1 = 5'd0;
        bus.enc_rs2 = 5'd0;
        bus.enc_funct3 = 3'd0;
        bus.enc_funct7b5 = 1'b0;
        bus.enc_imm = 32'd0;
        sbus.enc_valid = 1'b0;
        sbus.enc_kind = 3'd0;
        sbus.enc_rd = 5'd0;
        sbus.enc_rs1 = 5'd0;
        sbus.enc_rs2 = 5'd0;
        sbus.enc_funct3 = 3'd0;
        sbus.enc_funct7b5 = 1'b0;
        sbus.enc_imm = 32'd0;
        sbus.enc_last = 1'b0;
        test_reset();
        test_r_type();
        test_back_to_back();
        test_branch_jal();
        test_shift();
        test_errors();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
